ps2_keycode_rx: RTL and testbench
=================================

PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

Interface
REQ-001 SHALL have parameter FILT_LEN, default 8: consecutive equal clk samples needed to accept a new filtered ps2_clk level.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000: clk cycles without a filtered ps2_clk falling edge before a partial frame is abandoned.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 device clock; asynchronous.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 device data; asynchronous.
REQ-007 SHALL have port keycode  output  8  currently held make code; 0x00 when no key is held.
REQ-008 SHALL have port key_ext  output  1  high when the held keycode was prefixed by 0xE0.
REQ-009 SHALL have port key_valid  output  1  one-cycle pulse on each accepted make code, including typematic repeats.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a discarded frame.

Function
REQ-011 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any use.
REQ-012 SHALL update the filtered clock only after FILT_LEN consecutive identical synchronized samples; filtered clock resets to 1.
REQ-013 SHALL sample synchronized ps2_data on the clk cycle that detects a filtered-clock 1->0 transition.
REQ-014 SHALL run a frame FSM with states IDLE, DATA, PARITY, STOP, advancing once per falling-edge sample.
REQ-015 IDLE: sample 0 -> DATA with bit count 0; sample 1 -> stay IDLE, no error.
REQ-016 DATA: shift in 8 bits LSB first; after the 8th bit -> PARITY.
REQ-017 PARITY: capture parity bit -> STOP.
REQ-018 STOP: sample 1 with a valid frame -> byte accepted; sample 0 -> frame_err; both return to IDLE.
REQ-019 SHALL count clk cycles since the last falling edge while not in IDLE; on reaching TIMEOUT_CYC, return to IDLE and pulse frame_err.
REQ-020 SHALL present an accepted byte to the decoder on the clk cycle after the stop-bit sample.
REQ-021 Decoder: byte 0xE0 sets the pending-ext flag; keycode is unchanged.
REQ-022 Decoder: byte 0xF0 sets the pending-break flag; keycode is unchanged.
REQ-023 Decoder, other byte with break pending: if byte equals keycode and pending-ext equals key_ext, clear keycode to 0x00 and key_ext to 0; otherwise leave both unchanged.
REQ-024 Decoder, other byte without break pending: set keycode to the byte, key_ext to pending-ext, and pulse key_valid in the same cycle keycode updates.
REQ-025 Decoder SHALL clear both pending flags after every byte other than 0xE0 or 0xF0.
REQ-026 frame_err SHALL NOT disturb keycode, key_ext or pending flags.
REQ-027 SHALL NOT pulse key_valid and frame_err in the same cycle.
REQ-028 Response latency from the stop-bit falling edge (raw pin) to key_valid SHALL be 2 + FILT_LEN + 2 clk cycles, fixed.

Reset
REQ-029 With rst high at a clk edge, SHALL set: FSM to IDLE; bit count, shift register and timeout counter to 0; synchronizers and filtered clock to 1; pending flags to 0; keycode 0x00, key_ext 0, key_valid 0, frame_err 0.
REQ-030 Reset mid-frame SHALL discard the partial frame silently (no frame_err), and reception SHALL restart at the next start bit after rst deasserts.

Configuration
REQ-031 With PS2_PARITY_CHK_EN defined, a frame whose 8 data bits plus parity bit have even weight SHALL be discarded with frame_err in STOP; odd weight SHALL be valid.
REQ-032 Without PS2_PARITY_CHK_EN, the parity bit SHALL be captured and ignored, and any frame with a correct stop bit SHALL be accepted.

Verification
REQ-033 Frames 0xE0, 0x75 (correct parity) -> keycode=0x75, key_ext=1, one key_valid pulse.
REQ-034 Frames 0xE0, 0x75, then 0xE0, 0xF0, 0x75 -> keycode returns to 0x00, key_ext=0, no key_valid on the break.
REQ-035 Make 0x74 held; break F0 6B received -> keycode stays 0x74; make 0x74 repeated 3x -> 3 key_valid pulses.
REQ-036 Frame 0x72 sent with wrong parity -> with PS2_PARITY_CHK_EN: frame_err pulse, keycode unchanged; without it: keycode=0x72.
REQ-037 Stop ps2_clk after 4 data bits for more than TIMEOUT_CYC cycles -> frame_err pulse, FSM in IDLE; next frame 0x6B is decoded correctly.
REQ-038 1-cycle glitches on ps2_clk at FILT_LEN=8 -> no bit sampled; rst asserted mid-frame -> all outputs at reset values, no frame_err.

Source files
------------

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: sync, clock filter, frame FSM, make/break decoder.
// Optional parity checking: define PS2_PARITY_CHK_EN.
module ps2_keycode_rx #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_ext,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          par_ok;
  logic [TW-1:0] to_cnt;
  logic          byte_vld;

  logic          pend_ext;
  logic          pend_brk;

  // Two-flop synchronizers on both raw PS/2 pins
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Accept a new clock level only after FILT_LEN identical samples
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

`ifdef PS2_PARITY_CHK_EN
  assign par_ok = ^{shreg, par_bit};
`else
  // Parity bit is captured but never rejects a frame
  assign par_ok = par_bit | ~par_bit;
`endif

  // Frame FSM, one step per filtered falling edge, with stall timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        unique case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat_s2;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_s2 && par_ok)
              byte_vld <= 1'b1;
            else
              frame_err <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TMO_LAST) begin
        state     <= IDLE;
        to_cnt    <= '0;
        frame_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Make/break decoder fed by accepted bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      keycode   <= 8'h00;
      key_ext   <= 1'b0;
      key_valid <= 1'b0;
      pend_ext  <= 1'b0;
      pend_brk  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (byte_vld) begin
        if (shreg == 8'hE0) begin
          pend_ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          pend_brk <= 1'b1;
        end else begin
          pend_ext <= 1'b0;
          pend_brk <= 1'b0;
          if (pend_brk) begin
            if (shreg == keycode && pend_ext == key_ext) begin
              keycode <= 8'h00;
              key_ext <= 1'b0;
            end
          end else begin
            keycode   <= shreg;
            key_ext   <= pend_ext;
            key_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx.
// Frames are bit-banged on the raw pins with a slow PS/2 clock.
module tb_ps2_keycode_rx;

  localparam int FILT = 8;
  localparam int TMO  = 2000;
  localparam int HP   = 20;
  localparam int LAT  = 2 + FILT + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       key_ext;
  logic       key_valid;
  logic       frame_err;

  int cyc = 0;
  int kv_tot = 0;
  int fe_tot = 0;
  int both_tot = 0;
  int kv_last = 0;
  int stop_fall = 0;
  int checks = 0;
  int failures = 0;

  ps2_keycode_rx #(
    .FILT_LEN   (FILT),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .keycode  (keycode),
    .key_ext  (key_ext),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid) begin
      kv_tot++;
      kv_last = cyc;
    end
    if (frame_err) fe_tot++;
    if (key_valid && frame_err) both_tot++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (HP) @(negedge clk);
      if (i == 10) stop_fall = cyc;
      ps2_clk = 1'b0;
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * HP) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic bad_par,
                            input logic stop_v);
    logic p;
    p = ~(^b);
    if (bad_par) p = ~p;
    send_bits({stop_v, p, b, 1'b0}, 11);
  endtask

  task automatic test_reset();
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rst      = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (keycode !== 8'h00 || key_ext !== 1'b0 ||
        key_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: kc=%h ext=%b kv=%b fe=%b want 00 0 0 0",
               keycode, key_ext, key_valid, frame_err);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_ext_make();
    int kv0;
    kv0 = kv_tot;
    send_frame(8'hE0, 1'b0, 1'b1);
    checks++;
    if (kv_tot - kv0 !== 0) begin
      failures++;
      $display("FAIL e0_no_valid: pulses=%0d want 0", kv_tot - kv0);
    end
    send_frame(8'h75, 1'b0, 1'b1);
    checks++;
    if (keycode !== 8'h75 || key_ext !== 1'b1) begin
      failures++;
      $display("FAIL ext_make: kc=%h ext=%b want 75 1", keycode, key_ext);
    end
    checks++;
    if (kv_tot - kv0 !== 1) begin
      failures++;
      $display("FAIL ext_make_pulse: pulses=%0d want 1", kv_tot - kv0);
    end
    checks++;
    if (kv_last - stop_fall !== LAT) begin
      failures++;
      $display("FAIL latency: got %0d want %0d", kv_last - stop_fall, LAT);
    end
  endtask

  task automatic test_ext_break();
    int kv0;
    kv0 = kv_tot;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    checks++;
    if (keycode !== 8'h00 || key_ext !== 1'b0) begin
      failures++;
      $display("FAIL ext_break: kc=%h ext=%b want 00 0", keycode, key_ext);
    end
    checks++;
    if (kv_tot - kv0 !== 0) begin
      failures++;
      $display("FAIL ext_break_pulse: pulses=%0d want 0", kv_tot - kv0);
    end
  endtask

  task automatic test_typematic();
    int kv0;
    send_frame(8'h74, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h6B, 1'b0, 1'b1);
    checks++;
    if (keycode !== 8'h74 || key_ext !== 1'b0) begin
      failures++;
      $display("FAIL other_break: kc=%h ext=%b want 74 0", keycode, key_ext);
    end
    kv0 = kv_tot;
    for (int i = 0; i < 3; i++) send_frame(8'h74, 1'b0, 1'b1);
    checks++;
    if (kv_tot - kv0 !== 3 || keycode !== 8'h74) begin
      failures++;
      $display("FAIL typematic: pulses=%0d kc=%h want 3 74",
               kv_tot - kv0, keycode);
    end
  endtask

  task automatic test_parity();
    int fe0;
    fe0 = fe_tot;
    send_frame(8'h72, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHK_EN
    checks++;
    if (fe_tot - fe0 !== 1 || keycode !== 8'h74) begin
      failures++;
      $display("FAIL bad_parity: errs=%0d kc=%h want 1 74",
               fe_tot - fe0, keycode);
    end
`else
    checks++;
    if (fe_tot - fe0 !== 0 || keycode !== 8'h72) begin
      failures++;
      $display("FAIL bad_parity: errs=%0d kc=%h want 0 72",
               fe_tot - fe0, keycode);
    end
`endif
  endtask

  task automatic test_stop_err();
    int fe0;
    int kv0;
    logic [7:0] exp_kc;
`ifdef PS2_PARITY_CHK_EN
    exp_kc = 8'h74;
`else
    exp_kc = 8'h72;
`endif
    fe0 = fe_tot;
    kv0 = kv_tot;
    send_frame(8'h29, 1'b0, 1'b0);
    checks++;
    if (fe_tot - fe0 !== 1 || kv_tot - kv0 !== 0 || keycode !== exp_kc) begin
      failures++;
      $display("FAIL stop_err: errs=%0d pulses=%0d kc=%h want 1 0 %h",
               fe_tot - fe0, kv_tot - kv0, keycode, exp_kc);
    end
  endtask

  task automatic test_timeout();
    int fe0;
    int kv0;
    fe0 = fe_tot;
    kv0 = kv_tot;
    send_bits({3'b111, 8'hA5}, 5);
    repeat (TMO + 200) @(negedge clk);
    checks++;
    if (fe_tot - fe0 !== 1 || kv_tot - kv0 !== 0) begin
      failures++;
      $display("FAIL timeout: errs=%0d pulses=%0d want 1 0",
               fe_tot - fe0, kv_tot - kv0);
    end
    send_frame(8'h6B, 1'b0, 1'b1);
    checks++;
    if (keycode !== 8'h6B || key_ext !== 1'b0 || kv_tot - kv0 !== 1) begin
      failures++;
      $display("FAIL after_timeout: kc=%h ext=%b pulses=%0d want 6b 0 1",
               keycode, key_ext, kv_tot - kv0);
    end
  endtask

  task automatic test_glitch();
    int fe0;
    int kv0;
    fe0 = fe_tot;
    kv0 = kv_tot;
    @(negedge clk);
    ps2_data = 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      ps2_clk = 1'b0;
      @(negedge clk);
      ps2_clk = 1'b1;
      repeat (6) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (HP) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++;
    if (keycode !== 8'h1C || fe_tot - fe0 !== 0 || kv_tot - kv0 !== 1) begin
      failures++;
      $display("FAIL glitch: kc=%h errs=%0d pulses=%0d want 1c 0 1",
               keycode, fe_tot - fe0, kv_tot - kv0);
    end
  endtask

  task automatic test_reset_mid();
    int fe0;
    int kv0;
    fe0 = fe_tot;
    kv0 = kv_tot;
    send_bits({3'b111, 8'h33}, 4);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (keycode !== 8'h00 || key_ext !== 1'b0 ||
        key_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: kc=%h ext=%b kv=%b fe=%b want 00 0 0 0",
               keycode, key_ext, key_valid, frame_err);
    end
    rst = 1'b0;
    repeat (TMO + 100) @(negedge clk);
    checks++;
    if (fe_tot - fe0 !== 0 || kv_tot - kv0 !== 0) begin
      failures++;
      $display("FAIL mid_reset_quiet: errs=%0d pulses=%0d want 0 0",
               fe_tot - fe0, kv_tot - kv0);
    end
    send_frame(8'h5A, 1'b0, 1'b1);
    checks++;
    if (keycode !== 8'h5A || key_ext !== 1'b0 || kv_tot - kv0 !== 1) begin
      failures++;
      $display("FAIL restart: kc=%h ext=%b pulses=%0d want 5a 0 1",
               keycode, key_ext, kv_tot - kv0);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_tot !== 0) begin
      failures++;
      $display("FAIL exclusive: overlaps=%0d want 0", both_tot);
    end
  endtask

  initial begin
    test_reset();
    test_ext_make();
    test_ext_break();
    test_typematic();
    test_parity();
    test_stop_err();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
